psum_quant_tx: RTL and testbench
================================

# psum_quant_tx

Output-side drain for the dense core. It accepts psum rows of NUM_COLS × PSUM_BW bits from the PE array through a valid/ready handshake and holds them in a 2-entry row buffer. Each lane is requantized to signed 8-bit with multiply, rounding shift, zero point, optional ReLU and saturation. The bytes are serialized onto an 8-bit AXI-Stream master toward the AXI interface, lane 0 first, with tlast on the final byte of the tile.

## Interface
Parameters:
- PSUM_BW, 32, psum lane width
- NUM_COLS, 32, lanes per psum row
- OUT_BW, 8, output byte width
- MULT_BW, 16, requant multiplier width (unsigned)
- SHIFT_W, 5, requant shift width
- ROWS_W, 11, row-count width (2^11 > 32×32)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; latches configuration
- num_rows  in  ROWS_W  psum rows in this tile
- quant_mult  in  MULT_BW  multiplier
- quant_shift  in  SHIFT_W  arithmetic right shift
- zero_point  in  OUT_BW (signed)  output zero point
- relu_en  in  1  clamp the result below zero_point
- psum_valid  in  1  psum row offered
- psum_ready  out  1  row accepted when valid && ready
- psum_rows  in  PSUM_BW*NUM_COLS  row; lane i is bits [PSUM_BW*(i+1)-1 : PSUM_BW*i]
- m_axis_tdata  out  OUT_BW  quantized byte
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1  last byte of the tile
- busy  out  1  high from start until done
- done  out  1  one-cycle pulse after the final tlast handshake

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - On start, latch all config, clear the counters and go to RUN.
  - If num_rows == 0, go to DONE instead.
  - start is ignored outside IDLE.
- **Accept side:**
  - psum_ready = (RUN && buf_count < 2 && rows_accepted < num_rows_q).
  - psum_ready is driven from registers only; it does not depend on a pop in the same cycle.
  - Rows beyond num_rows_q are never accepted.
- **Drain side:**
  - When the pipeline advances and the buffer is non-empty, the lane counter (0..NUM_COLS-1) issues lane[lane_cnt] of the head entry into the pipeline.
  - Issuing lane NUM_COLS-1 pops the head entry and wraps lane_cnt to 0.
  - A push and a pop in the same cycle leave buf_count unchanged.
- **Pipeline advance:** adv = !m_axis_tvalid || m_axis_tready. Every stage holds when adv is low.
- **Requantization, per lane:**
  - prod = signed(psum) × unsigned(quant_mult), 48-bit signed.
  - rnd = (shift == 0) ? 0 : 1 << (shift-1).
  - q = (prod + rnd) >>> shift.
  - v = q + zero_point.
  - If relu_en && v < zero_point, then v = zero_point.
  - Saturate v to [-128, 127].
- **tlast:** high with the byte from the last lane of row num_rows_q-1.
- **Completion:**
  - The tlast handshake moves the FSM RUN → DONE.
  - DONE asserts done for 1 cycle, then returns to IDLE.
  - busy = (state != IDLE).

## Timing
- **Reset values:** psum_ready 0, m_axis_tvalid 0, m_axis_tdata 0, m_axis_tlast 0, busy 0, done 0. The FSM is in IDLE and the buffer is empty.
- **Reset mid-operation:** asynchronous clear; tvalid drops immediately. Partial tile output is discarded; no done pulse.
- **Latency:**
  - A row accepted at clock edge E0 is issued at E1 (stage 1: product register).
  - Stage 2 (round/zp/clamp and output register) completes at E2, so tvalid is high after E2.
  - First byte therefore appears 2 cycles after acceptance.
- **Throughput:** 1 byte/cycle with tready held high. Rows offered every ≥32 cycles never see psum_ready low.
- **AXIS rule:** tdata and tlast stay stable while tvalid && !tready. tvalid never drops without a handshake.
- **done timing:** done is high in the cycle after the tlast handshake edge.
- **num_rows == 0:** done is high the cycle after start; no beats are sent.

## Structure
- **Package psum_quant_pkg:**
  - width localparams (PSUM_BW, OUT_BW, product width 48)
  - the state encoding IDLE/RUN/DONE
  - saturation limits -128/127
  - a requant function used by the bench model
- **Sub-module psum_requant_lane:**
  - 2-stage pipeline: multiply, then round/shift/zero-point/ReLU/clamp.
  - Inputs: psum, config, enable (adv), in_valid, in_last.
  - Outputs: byte, out_valid, out_last.
- **Top level:** FSM, 2-entry row buffer with pointers and count, lane mux and counters.

## Test plan
- **Basic single row:** num_rows=1, mult=1, shift=0, zp=0, lane i = i-16, tready=1 → 32 consecutive bytes -16..15. tlast only on byte 32; done 1 cycle later; first tvalid 2 cycles after acceptance.
- **Rounding and saturation:** mult=3, shift=2, zp=0; lanes 5, -5, 1000, -1000 → 4, -4, 127, -128.
- **ReLU:** relu_en=1, zp=-10, mult=1, shift=0, psum=-100 → -10; psum=50 → 40.
- **Backpressure:** num_rows=3, psum_valid always high, tready alternating 1/0 → exactly 96 bytes in lane/row order. Data held while stalled; psum_ready low while 2 rows are buffered; tlast only on byte 96.
- **Empty tile:** num_rows=0 → done pulses the cycle after start, tvalid never asserted. A 4th row offered after a 3-row tile completes is not accepted (psum_ready=0).
- **Reset mid-tile:** reset asserted after beat 10 → all outputs take their reset values immediately. A new start with num_rows=1 then yields a clean 32-byte tile.

Source files
------------

// File: rtl/psum_quant_pkg.sv
// rtl/psum_quant_pkg.sv - shared widths, state encoding and requant arithmetic for the psum drain
package psum_quant_pkg;

    localparam int PSUM_BW  = 32;
    localparam int NUM_COLS = 32;
    localparam int OUT_BW   = 8;
    localparam int MULT_BW  = 16;
    localparam int SHIFT_W  = 5;
    localparam int ROWS_W   = 11;
    localparam int PROD_W   = 48;

    localparam int SAT_MIN = -128;
    localparam int SAT_MAX = 127;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Second half of the requant: round, shift, zero point, ReLU, saturate.
    // One guard bit above PROD_W keeps the rounding add and zp add from wrapping.
    function automatic logic [OUT_BW-1:0] requant_prod(
        input logic signed [PROD_W-1:0] prod,
        input logic        [SHIFT_W-1:0] shift,
        input logic signed [OUT_BW-1:0]  zp,
        input logic                      relu
    );
        logic signed [PROD_W:0] rnd;
        logic signed [PROD_W:0] q;
        logic signed [PROD_W:0] v;
        logic signed [PROD_W:0] zp_x;
        rnd = '0;
        if (shift != '0) begin
            rnd = (PROD_W+1)'(1) << (shift - SHIFT_W'(1));
        end
        zp_x = (PROD_W+1)'(zp);
        q = ($signed({prod[PROD_W-1], prod}) + rnd) >>> shift;
        v = q + zp_x;
        if (relu && (v < zp_x)) begin
            v = zp_x;
        end
        if (v > (PROD_W+1)'(SAT_MAX)) begin
            v = (PROD_W+1)'(SAT_MAX);
        end else if (v < (PROD_W+1)'(SAT_MIN)) begin
            v = (PROD_W+1)'(SAT_MIN);
        end
        return v[OUT_BW-1:0];
    endfunction

endpackage

// File: rtl/psum_requant_lane.sv
// rtl/psum_requant_lane.sv - two-stage requant pipeline: multiply, then round/zp/ReLU/clamp
module psum_requant_lane
    import psum_quant_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      in_valid,
    input  logic                      in_last,
    input  logic [PSUM_BW-1:0]        psum,
    input  logic [MULT_BW-1:0]        mult,
    input  logic [SHIFT_W-1:0]        shift,
    input  logic signed [OUT_BW-1:0]  zp,
    input  logic                      relu,
    output logic [OUT_BW-1:0]         out_byte,
    output logic                      out_valid,
    output logic                      out_last
);

    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic                     s1_valid_q, s1_valid_d;
    logic                     s1_last_q, s1_last_d;
    logic [OUT_BW-1:0]        byte_q, byte_d;
    logic                     s2_valid_q, s2_valid_d;
    logic                     s2_last_q, s2_last_d;
    logic signed [PROD_W-1:0] psum_x;
    logic signed [PROD_W-1:0] mult_x;

    always_comb begin
        psum_x     = PROD_W'($signed(psum));
        mult_x     = PROD_W'(mult);
        prod_d     = prod_q;
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        byte_d     = byte_q;
        s2_valid_d = s2_valid_q;
        s2_last_d  = s2_last_q;
        if (en) begin
            prod_d     = psum_x * mult_x;
            s1_valid_d = in_valid;
            s1_last_d  = in_last;
            byte_d     = requant_prod(prod_q, shift, zp, relu);
            s2_valid_d = s1_valid_q;
            s2_last_d  = s1_last_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            byte_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
        end else begin
            prod_q     <= prod_d;
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            byte_q     <= byte_d;
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
        end
    end

    assign out_byte  = byte_q;
    assign out_valid = s2_valid_q;
    assign out_last  = s2_last_q;

endmodule

// File: rtl/psum_quant_tx.sv
// rtl/psum_quant_tx.sv - psum row buffer, lane serializer and byte stream master for the dense core
module psum_quant_tx #(
    parameter int PSUM_BW  = 32,
    parameter int NUM_COLS = 32,
    parameter int OUT_BW   = 8,
    parameter int MULT_BW  = 16,
    parameter int SHIFT_W  = 5,
    parameter int ROWS_W   = 11
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [ROWS_W-1:0]            num_rows,
    input  logic [MULT_BW-1:0]           quant_mult,
    input  logic [SHIFT_W-1:0]           quant_shift,
    input  logic signed [OUT_BW-1:0]     zero_point,
    input  logic                         relu_en,
    input  logic                         psum_valid,
    output logic                         psum_ready,
    input  logic [PSUM_BW*NUM_COLS-1:0]  psum_rows,
    output logic [OUT_BW-1:0]            m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic                         busy,
    output logic                         done
);
    import psum_quant_pkg::*;

    localparam int ROW_W  = PSUM_BW * NUM_COLS;
    localparam int LANE_W = $clog2(NUM_COLS);

    state_t                   state_q, state_d;
    logic [ROWS_W-1:0]        num_rows_q, num_rows_d;
    logic [ROWS_W-1:0]        rows_acc_q, rows_acc_d;
    logic [ROWS_W-1:0]        rows_iss_q, rows_iss_d;
    logic [MULT_BW-1:0]       mult_q, mult_d;
    logic [SHIFT_W-1:0]       shift_q, shift_d;
    logic signed [OUT_BW-1:0] zp_q, zp_d;
    logic                     relu_q, relu_d;
    logic                     wr_ptr_q, wr_ptr_d;
    logic                     rd_ptr_q, rd_ptr_d;
    logic [1:0]               cnt_q, cnt_d;
    logic [LANE_W-1:0]        lane_q, lane_d;
    logic [ROW_W-1:0]         row_buf [2];

    logic                     adv, push, issue, pop, issue_last, hs_last;
    logic [PSUM_BW-1:0]       lane_data;

    assign adv        = !m_axis_tvalid || m_axis_tready;
    assign psum_ready = (state_q == ST_RUN) && (cnt_q < 2'd2) && (rows_acc_q < num_rows_q);
    assign push       = psum_valid && psum_ready;
    assign issue      = (state_q == ST_RUN) && adv && (cnt_q != 2'd0);
    assign pop        = issue && (lane_q == LANE_W'(NUM_COLS - 1));
    assign issue_last = pop && (rows_iss_q == num_rows_q - ROWS_W'(1));
    assign hs_last    = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    assign lane_data  = row_buf[rd_ptr_q][lane_q*PSUM_BW +: PSUM_BW];
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);

    always_comb begin
        state_d    = state_q;
        num_rows_d = num_rows_q;
        rows_acc_d = rows_acc_q;
        rows_iss_d = rows_iss_q;
        mult_d     = mult_q;
        shift_d    = shift_q;
        zp_d       = zp_q;
        relu_d     = relu_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        lane_d     = lane_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_rows_d = num_rows;
                    mult_d     = quant_mult;
                    shift_d    = quant_shift;
                    zp_d       = zero_point;
                    relu_d     = relu_en;
                    rows_acc_d = '0;
                    rows_iss_d = '0;
                    wr_ptr_d   = 1'b0;
                    rd_ptr_d   = 1'b0;
                    cnt_d      = 2'd0;
                    lane_d     = '0;
                    state_d    = (num_rows == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (push) begin
                    wr_ptr_d   = !wr_ptr_q;
                    rows_acc_d = rows_acc_q + ROWS_W'(1);
                end
                if (issue) begin
                    lane_d = pop ? '0 : lane_q + LANE_W'(1);
                end
                if (pop) begin
                    rd_ptr_d   = !rd_ptr_q;
                    rows_iss_d = rows_iss_q + ROWS_W'(1);
                end
                if (push && !pop) begin
                    cnt_d = cnt_q + 2'd1;
                end else if (pop && !push) begin
                    cnt_d = cnt_q - 2'd1;
                end
                if (hs_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            num_rows_q <= '0;
            rows_acc_q <= '0;
            rows_iss_q <= '0;
            mult_q     <= '0;
            shift_q    <= '0;
            zp_q       <= '0;
            relu_q     <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
            lane_q     <= '0;
        end else begin
            state_q    <= state_d;
            num_rows_q <= num_rows_d;
            rows_acc_q <= rows_acc_d;
            rows_iss_q <= rows_iss_d;
            mult_q     <= mult_d;
            shift_q    <= shift_d;
            zp_q       <= zp_d;
            relu_q     <= relu_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            lane_q     <= lane_d;
        end
    end

    // Row payload needs no reset: cnt_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            row_buf[wr_ptr_q] <= psum_rows;
        end
    end

    psum_requant_lane u_lane (
        .clk       (clk),
        .rst       (reset),
        .en        (adv),
        .in_valid  (issue),
        .in_last   (issue_last),
        .psum      (lane_data),
        .mult      (mult_q),
        .shift     (shift_q),
        .zp        (zp_q),
        .relu      (relu_q),
        .out_byte  (m_axis_tdata),
        .out_valid (m_axis_tvalid),
        .out_last  (m_axis_tlast)
    );

endmodule

// File: tb/tb_psum_quant_tx.sv
// tb/tb_psum_quant_tx.sv - self-checking bench for psum_quant_tx against an arithmetic reference model
module tb_psum_quant_tx;

    localparam int NC = 32;
    localparam int PB = 32;
    localparam int RW = 11;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [RW-1:0]     num_rows;
    logic [15:0]       quant_mult;
    logic [4:0]        quant_shift;
    logic signed [7:0] zero_point;
    logic              relu_en;
    logic              psum_valid;
    logic              psum_ready;
    logic [PB*NC-1:0]  psum_rows;
    logic [7:0]        m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    psum_quant_tx dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .num_rows      (num_rows),
        .quant_mult    (quant_mult),
        .quant_shift   (quant_shift),
        .zero_point    (zero_point),
        .relu_en       (relu_en),
        .psum_valid    (psum_valid),
        .psum_ready    (psum_ready),
        .psum_rows     (psum_rows),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .done          (done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit ready_low_seen;
    logic [PB*NC-1:0] row_mem [4];
    int exp_q[$];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int model_byte(input logic [31:0] p, input int mult, input int sh, input int zp, input bit relu);
        longint prod, rnd, q, v;
        prod = longint'($signed(p)) * longint'(mult);
        rnd  = (sh == 0) ? 64'sd0 : (longint'(1) << (sh - 1));
        q    = (prod + rnd) >>> sh;
        v    = q + zp;
        if (relu && v < zp) v = zp;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return int'(v);
    endfunction

    task automatic fill_random(input int r);
        for (int i = 0; i < NC; i++) begin
            case ($urandom_range(0, 2))
                0: row_mem[r][i*PB +: PB] = $urandom;
                1: row_mem[r][i*PB +: PB] = 32'($signed($urandom_range(0, 400)) - 200);
                default: row_mem[r][i*PB +: PB] = 32'($signed($urandom_range(0, 200000)) - 100000);
            endcase
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_psum_ready"}, psum_ready, 0);
        check({tag, "_tvalid"}, m_axis_tvalid, 0);
        check({tag, "_tdata"}, m_axis_tdata, 0);
        check({tag, "_tlast"}, m_axis_tlast, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // rdy_mode: 0 held high, 1 alternating, 2 random. vld_mode: 0 always offered, 1 random.
    task automatic run_tile(input string tag, input int nrows, input int mult, input int sh, input int zp,
                            input bit relu, input int rdy_mode, input int vld_mode, input int abort_at);
        int  acc = 0, beats = 0, total, start_cyc;
        int  acc_cyc = -1, vld_cyc = -1, hs_cyc = -1, done_cyc = -1;
        bit  stall = 0;
        logic [7:0] pd;
        logic pl;
        total = nrows * NC;
        ready_low_seen = 0;
        exp_q.delete();
        for (int r = 0; r < nrows; r++)
            for (int i = 0; i < NC; i++)
                exp_q.push_back(model_byte(row_mem[r][i*PB +: PB], mult, sh, zp, relu));
        num_rows    = RW'(nrows);
        quant_mult  = 16'(mult);
        quant_shift = 5'(sh);
        zero_point  = 8'(zp);
        relu_en     = relu;
        start       = 1'b1;
        step();
        start       = 1'b0;
        start_cyc   = cyc;
        if (nrows > 0) check({tag, "_busy"}, busy, 1);
        for (int c = 0; c < 3000; c++) begin
            m_axis_tready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'((c % 2) == 0) : 1'($urandom_range(0, 1));
            psum_valid    = (vld_mode == 0) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
            psum_rows     = row_mem[acc % 4];
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (stall) begin
                check({tag, "_hold_tvalid"}, m_axis_tvalid, 1);
                check({tag, "_hold_tdata"}, m_axis_tdata, pd);
                check({tag, "_hold_tlast"}, m_axis_tlast, pl);
            end
            if (psum_valid && psum_ready) begin
                check({tag, "_row_beyond_num_rows"}, acc < nrows, 1);
                if (acc_cyc < 0) acc_cyc = cyc + 1;
                acc++;
            end
            if (psum_valid && !psum_ready && acc < nrows) ready_low_seen = 1;
            if (m_axis_tvalid && vld_cyc < 0) vld_cyc = cyc;
            if (m_axis_tvalid && m_axis_tready) begin
                if (beats < total) begin
                    check($sformatf("%s_data_b%0d", tag, beats), $signed(m_axis_tdata), exp_q[beats]);
                    check($sformatf("%s_tlast_b%0d", tag, beats), m_axis_tlast, beats == total - 1);
                end else begin
                    check({tag, "_extra_beat"}, beats, total - 1);
                end
                if (m_axis_tlast) hs_cyc = cyc;
                beats++;
            end
            stall = m_axis_tvalid && !m_axis_tready;
            pd = m_axis_tdata;
            pl = m_axis_tlast;
            if (abort_at > 0 && beats == abort_at) begin
                reset = 1'b1;
                #1;
                check_reset_outputs({tag, "_async_reset"});
                psum_valid = 1'b0;
                step();
                check_reset_outputs({tag, "_held_reset"});
                reset = 1'b0;
                step();
                check({tag, "_no_done_after_abort"}, done, 0);
                return;
            end
            step();
        end
        check({tag, "_beat_count"}, beats, total);
        if (nrows == 0) begin
            check({tag, "_done_after_start"}, done_cyc, start_cyc);
            check({tag, "_no_tvalid"}, vld_cyc, -1);
        end else begin
            check({tag, "_done_after_tlast"}, done_cyc, hs_cyc + 1);
            check({tag, "_first_byte_latency"}, vld_cyc - acc_cyc, 2);
        end
        psum_valid    = 1'b0;
        m_axis_tready = 1'b1;
        step();
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_busy_cleared"}, busy, 0);
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        num_rows      = '0;
        quant_mult    = '0;
        quant_shift   = '0;
        zero_point    = '0;
        relu_en       = 1'b0;
        psum_valid    = 1'b0;
        psum_rows     = '0;
        m_axis_tready = 1'b1;
        step();
        step();
        check_reset_outputs("reset");
        reset = 1'b0;
        step();

        for (int i = 0; i < NC; i++) row_mem[0][i*PB +: PB] = 32'(i - 16);
        run_tile("basic", 1, 1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < NC; i++) begin
            case (i % 4)
                0: row_mem[0][i*PB +: PB] = 32'sd5;
                1: row_mem[0][i*PB +: PB] = -32'sd5;
                2: row_mem[0][i*PB +: PB] = 32'sd1000;
                default: row_mem[0][i*PB +: PB] = -32'sd1000;
            endcase
        end
        run_tile("round_sat", 1, 3, 2, 0, 0, 0, 0, 0);

        for (int i = 0; i < NC; i++) row_mem[0][i*PB +: PB] = (i % 2 == 0) ? -32'sd100 : 32'sd50;
        run_tile("relu", 1, 1, 0, -10, 1, 0, 0, 0);

        for (int r = 0; r < 3; r++) fill_random(r);
        run_tile("backpressure", 3, 1, 0, 0, 0, 1, 0, 0);
        check("backpressure_ready_low_seen", ready_low_seen, 1);

        psum_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("fourth_row_refused", psum_ready, 0);
            step();
        end
        psum_valid = 1'b0;

        run_tile("empty", 0, 1, 0, 0, 0, 0, 0, 0);

        for (int t = 0; t < 3; t++) begin
            int nr;
            nr = $urandom_range(1, 4);
            for (int r = 0; r < nr; r++) fill_random(r);
            run_tile($sformatf("rand%0d", t), nr, $urandom_range(0, 65535), $urandom_range(6, 22),
                     $urandom_range(0, 255) - 128, 1'($urandom_range(0, 1)), 2, 1, 0);
        end

        for (int r = 0; r < 2; r++) fill_random(r);
        run_tile("abort", 2, 200, 8, 3, 0, 0, 0, 10);
        for (int i = 0; i < NC; i++) row_mem[0][i*PB +: PB] = 32'(i - 16);
        run_tile("after_reset", 1, 1, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
